// File: rtl/data_skew_feeder.sv
// Skews row vectors into a systolic array: lane r is delayed r+1 cycles so that
// element r of each vector reaches its row one cycle after element r-1.
module data_skew_feeder #(
  parameter int ROWS = 4,
  parameter int DW   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [ROWS*DW-1:0]   i_vec,
  input  logic                 i_last,
  output logic [ROWS*DW-1:0]   o_row_data,
  output logic [ROWS-1:0]      o_row_valid,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int CW = $clog2(ROWS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_d;
  logic            xfer;

  assign o_ready = i_rstn && (state_q != DRAIN);
  assign xfer    = i_valid && o_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, STREAM: begin
        if (xfer) begin
          if (i_last) begin
            state_d = DRAIN;
            cnt_d   = CW'(ROWS - 1);
          end else begin
            state_d = STREAM;
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        // Leaving DRAIN is the edge at which the last element reaches lane ROWS-1.
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      o_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_done  <= done_d;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DW-1:0] d_q [0:r];
    logic          v_q [0:r];

    // NOTE: delay-line data is reset too, since a bubble must read as 0 and a reset must flush in-flight elements.
    always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
        for (int i = 0; i <= r; i++) begin
          d_q[i] <= '0;
          v_q[i] <= 1'b0;
        end
      end else begin
        d_q[0] <= xfer ? i_vec[r*DW +: DW] : '0;
        v_q[0] <= xfer;
        for (int i = 1; i <= r; i++) begin
          d_q[i] <= d_q[i-1];
          v_q[i] <= v_q[i-1];
        end
      end
    end

    assign o_row_data[r*DW +: DW] = d_q[r];
    assign o_row_valid[r]         = v_q[r];
  end

  assign o_busy = (state_q != IDLE) || (|o_row_valid);

endmodule

// File: doc/data_skew_feeder.md
DATA_SKEW_FEEDER -- requirements
Module: data_skew_feeder

Interface
REQ-001 Parameter ROWS, default 4, SHALL set the number of systolic rows (lanes) fed; legal range 2..16.
REQ-002 Parameter DW, default 32, SHALL set the per-lane data width, matching the MAC data input width.
REQ-003 i_clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 i_rstn  input  1  SHALL be a synchronous, active-low reset.
REQ-005 i_valid  input  1  SHALL indicate that i_vec and i_last are valid.
REQ-006 o_ready  output  1  SHALL indicate that the block accepts i_vec this cycle; a vector transfers at a rising edge where i_valid=1 and o_ready=1.
REQ-007 i_vec  input  ROWS*DW  SHALL carry one element per lane; lane r occupies bits [r*DW +: DW].
REQ-008 i_last  input  1  SHALL mark the final vector of a tile; it is sampled only on a transfer.
REQ-009 o_row_data  output  ROWS*DW  SHALL carry the skewed per-lane data to the array row inputs, using the same lane packing as i_vec.
REQ-010 o_row_valid  output  ROWS  SHALL flag valid data per lane.
REQ-011 o_busy  output  1  SHALL be 1 whenever state!=IDLE or any bit of o_row_valid is 1.
REQ-012 o_done  output  1  SHALL pulse for one cycle when the last element of a tile appears on lane ROWS-1.

Function
REQ-013 Element r of a vector transferred at edge k SHALL appear on lane r, with o_row_valid[r]=1, in the cycle following edge k+r (lane latency r+1 edges).
REQ-014 A cycle without a transfer SHALL inject a bubble into every lane: data 0 and valid 0, skew-delayed identically to real data, so that downstream MACs accumulate 0.
REQ-015 Lane delay lines SHALL be plain shift registers that advance every cycle; the array applies no back-pressure and the block has no stall input.
REQ-016 The FSM SHALL have three states: IDLE, STREAM and DRAIN.
REQ-017 IDLE SHALL drive o_ready=1. A transfer with i_last=0 SHALL go to STREAM; a transfer with i_last=1 SHALL go to DRAIN.
REQ-018 STREAM SHALL drive o_ready=1. A transfer with i_last=1 SHALL go to DRAIN; any other cycle SHALL stay in STREAM, with bubbles permitted.
REQ-019 DRAIN SHALL drive o_ready=0.
REQ-020 DRAIN SHALL load a down-counter with ROWS-1 on entry and remain for ROWS-1 cycles.
REQ-021 DRAIN SHALL return to IDLE at edge k+ROWS-1, where k is the edge of the i_last transfer.
REQ-022 The first new transfer after a tile SHALL be possible no earlier than edge k+ROWS.
REQ-023 i_valid asserted during DRAIN SHALL NOT be accepted; the upstream source holds i_vec until o_ready=1.
REQ-024 o_done SHALL be registered, set at edge k+ROWS-1, and high for exactly that cycle, coincident with o_row_valid[ROWS-1] for the last element.
REQ-025 Data SHALL pass through unmodified, with no arithmetic and no width change.

Reset
REQ-026 While i_rstn=0 at a rising edge, the block SHALL set state=IDLE, clear the drain counter, and clear all delay-line data and valid bits.
REQ-027 After that reset edge, o_row_data=0, o_row_valid=0, o_done=0 and o_busy=0.
REQ-028 o_ready SHALL be 0 while i_rstn=0.
REQ-029 A reset asserted mid-tile SHALL discard all in-flight elements, and no o_done SHALL follow.

Verification (ROWS=4, DW=32)
REQ-030 Single-vector tile: i_vec lanes3..0={4,3,2,1} with i_last=1 transferred at edge 1 -> lane0=1 after edge 1, lane1=2 after edge 2, lane2=3 after edge 3, lane3=4 after edge 4 with o_done=1; o_ready=0 after edges 1-3 and 1 after edge 4.
REQ-031 Back-to-back tile: vectors {1,1,1,1}, {2,2,2,2}, {3,3,3,3} transferred at edges 1-3, last on the third -> each lane r shows 1,2,3 on consecutive cycles starting after edge 1+r; exactly one o_done, after edge 6.
REQ-032 Bubble: transfer at edge 1, none at edge 2, transfer at edge 3 -> on each lane r, the slot after edge 2+r has data 0 and valid 0, and the skew is preserved.
REQ-033 Hold during DRAIN: i_valid=1 with {9,9,9,9} held from the cycle after edge 1 (edge 1 carried i_last) -> not accepted at edges 2-4, accepted at edge 5, and lane0=9 after edge 5.
REQ-034 Reset mid-stream: i_rstn=0 at edge 3 of a 5-vector tile -> after edge 3 all outputs 0, o_busy=0, and no o_done; the next transfer starts a fresh tile with correct skew.
REQ-035 Random: random i_valid and i_last over 1000 cycles -> the per-lane output stream equals the reference-model stream, each lane delayed by r+1 edges, and the o_done count equals the number of tiles.
